h_xor16: RTL and testbench
==========================

# h_xor16

Bitwise 16-bit XOR unit of the base logic library, used by the ALU and datapath wherever two words must be XOR-combined. It provides a zero-latency combinational result for gate-level use and a registered result stage with a valid/ready handshake. The registered stage also carries derived flags: zero, parity and population count. It sits between operand sources and downstream consumers that may apply backpressure.

## Interface
- WIDTH, 16: operand and result width in bits. All values in this document assume 16.
- clk  input  1  rising-edge clock for the registered stage.
- rst_n  input  1  reset, asynchronous, active-low.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out  output  WIDTH  combinational a ^ b.
- in_valid  input  1  a/b hold an operand pair to be registered.
- in_ready  output  1  stage can accept a pair this cycle.
- out_valid  output  1  registered result and flags are valid.
- out_ready  input  1  consumer takes the registered result this cycle.
- out_q  output  WIDTH  registered a ^ b.
- zero_q  output  1  registered: result == 0.
- parity_q  output  1  registered XOR-reduction of the result; 1 when the popcount is odd.
- popcnt_q  output  5  registered count of 1 bits in the result, range 0..16.

## Operation
- out = a ^ b, bit for bit, at all times.
  - Independent of clk, rst_n and the handshake, including during reset.
- Transfer in: in_valid && in_ready at a rising edge.
  - Captures out_q = a ^ b.
  - Captures zero_q, parity_q and popcnt_q, all computed from that same result.
  - Sets out_valid = 1.
- Transfer out: out_valid && out_ready at a rising edge.
  - Without a simultaneous transfer in, out_valid clears to 0.
- in_ready = !out_valid || out_ready, combinational (single-entry pipeline register).
  - Back-to-back transfers at one per cycle are allowed when out_ready = 1.
- Simultaneous transfer in and transfer out in one cycle:
  - The old result is consumed and the new result is loaded.
  - out_valid stays 1.
- out_valid = 1 and out_ready = 0:
  - in_ready = 0.
  - out_q and all flags hold their values.
  - in_valid is ignored; no data is lost or overwritten.
- in_valid = 0: registers hold; out_valid is affected only by transfer out.
- No overflow or carry exists; the popcount fits 5 bits unsigned, with a maximum of 16.

## Timing
- out: zero cycles; purely combinational.
- Registered result latency: 1 cycle. Values are visible after the rising edge on which the transfer in occurs.
- Reset (rst_n = 0), asynchronous and immediate, independent of clk:
  - out_valid = 0, out_q = 0, zero_q = 0, parity_q = 0, popcnt_q = 0.
  - zero_q resets to 0 by decision, because no valid result exists.
  - in_ready = 1 while in reset (follows from out_valid = 0).
- Reset mid-operation discards any held result.
- Deassertion of rst_n: takes effect on the first rising edge after release.
  - The first transfer in can occur on that edge.
- Flags are never observed while out_valid = 0. They reflect the last loaded result or reset values.

## Test plan
- Reset, then a = 0x0000, b = 0x0000, with in_valid held.
  - out = 0x0000.
  - After 1 edge: out_q = 0x0000, zero_q = 1, parity_q = 0, popcnt_q = 0, out_valid = 1.
- a = 0xFFFF, b = 0xFFFF.
  - out = 0x0000 immediately.
  - Registered: zero_q = 1, popcnt_q = 0, parity_q = 0.
- a = 0xAAAA, b = 0x5555.
  - out = 0xFFFF.
  - Registered: out_q = 0xFFFF, zero_q = 0, popcnt_q = 16, parity_q = 0.
- a = 0x0001, b = 0x0000, then hold out_ready = 0 for 3 cycles and present a = 0x1234, b = 0x0000.
  - in_ready = 0 throughout the hold.
  - out_q stays 0x0001 with popcnt_q = 1 and parity_q = 1.
  - After out_ready rises, 0x1234 loads the next cycle with popcnt_q = 5.
- Streaming with out_ready = 1: 4 random pairs on consecutive cycles.
  - One result per cycle, each equal to a ^ b of the prior cycle.
  - out_valid stays continuously 1.
- Assert rst_n = 0 asynchronously between edges while out_valid = 1.
  - out_valid, out_q and all flags go to 0 immediately.
  - out still tracks a ^ b.

Source files
------------

// File: rtl/h_xor16_if.sv
// Operand/result bundle for the h_xor16 XOR unit: combinational path,
// input handshake and registered result with derived flags.
interface h_xor16_if #(
  parameter int WIDTH = 16
);
  localparam int PCW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_q;
  logic             zero_q;
  logic             parity_q;
  logic [PCW-1:0]   popcnt_q;

  // Operand source / result consumer side
  modport master (
    output a, b, in_valid, out_ready,
    input  out, in_ready, out_valid, out_q, zero_q, parity_q, popcnt_q
  );

  // XOR unit side
  modport slave (
    input  a, b, in_valid, out_ready,
    output out, in_ready, out_valid, out_q, zero_q, parity_q, popcnt_q
  );
endinterface

// File: rtl/h_xor16.sv
// Bitwise XOR unit: zero-latency a ^ b plus a single-entry registered stage
// (valid/ready) carrying the result with zero, parity and popcount flags.
module h_xor16 #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  h_xor16_if.slave  bus
);
  localparam int PCW = $clog2(WIDTH + 1);

  // Count of set bits; width PCW holds the full range 0..WIDTH.
  function automatic logic [PCW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PCW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + PCW'(v[i]);
    end
    return n;
  endfunction

  logic [WIDTH-1:0] res_p0;
  logic             in_rdy;
  logic             take_p0;

  logic [WIDTH-1:0] res_p1;
  logic             zero_p1;
  logic             par_p1;
  logic [PCW-1:0]   pop_p1;
  logic             vld_p1;

  assign res_p0  = bus.a ^ bus.b;
  assign in_rdy  = !vld_p1 || bus.out_ready;
  assign take_p0 = bus.in_valid && in_rdy;

  // ---- stage p0 -> p1: capture result and flags, track occupancy ----
  // Data is reset too so a discarded result never lingers on out_q/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      res_p1  <= '0;
      zero_p1 <= 1'b0;
      par_p1  <= 1'b0;
      pop_p1  <= '0;
    end else begin
      if (take_p0) begin
        vld_p1  <= 1'b1;
        res_p1  <= res_p0;
        zero_p1 <= (res_p0 == '0);
        par_p1  <= ^res_p0;
        pop_p1  <= popcount(res_p0);
      end else if (bus.out_ready) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign bus.out       = res_p0;
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_p1;
  assign bus.out_q     = res_p1;
  assign bus.zero_q    = zero_p1;
  assign bus.parity_q  = par_p1;
  assign bus.popcnt_q  = pop_p1;
endmodule

// File: tb/tb_h_xor16.sv
// Directed bench for h_xor16: reset state, combinational XOR, registered
// result and flags, backpressure hold, streaming and asynchronous reset.
module tb_h_xor16;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  h_xor16_if #(.WIDTH(16)) bus ();

  h_xor16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] sa [4];
  logic [15:0] sb [4];
  logic [15:0] sx [4];
  logic [4:0]  sp [4];

  initial begin
    n_chk  = 0;
    n_pass = 0;
    sa = '{16'h1357, 16'hFFFF, 16'h8000, 16'h00FF};
    sb = '{16'h2468, 16'h0001, 16'h8000, 16'h0F0F};
    sx = '{16'h373F, 16'hFFFE, 16'h0000, 16'h0FF0};
    sp = '{5'd11,    5'd15,    5'd0,     5'd8};

    rst_n         = 1'b0;
    bus.a         = 16'h0000;
    bus.b         = 16'h0000;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_valid",  32'(bus.out_valid), 32'd0);
    chk("rst_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_q",  32'(bus.out_q),     32'd0);
    chk("rst_zero",   32'(bus.zero_q),    32'd0);
    chk("rst_pop",    32'(bus.popcnt_q),  32'd0);
    bus.a = 16'h00F0;
    bus.b = 16'h0F00;
    #1;
    chk("rst_comb",   32'(bus.out),       32'h0FF0);

    @(negedge clk);
    rst_n        = 1'b1;
    bus.a        = 16'h0000;
    bus.b        = 16'h0000;
    bus.in_valid = 1'b1;
    #1;
    chk("z_comb", 32'(bus.out), 32'h0000);
    edge_wait();
    chk("z_out_q",  32'(bus.out_q),     32'h0000);
    chk("z_zero",   32'(bus.zero_q),    32'd1);
    chk("z_par",    32'(bus.parity_q),  32'd0);
    chk("z_pop",    32'(bus.popcnt_q),  32'd0);
    chk("z_valid",  32'(bus.out_valid), 32'd1);

    bus.a = 16'hFFFF;
    bus.b = 16'hFFFF;
    #1;
    chk("ff_comb", 32'(bus.out), 32'h0000);
    edge_wait();
    chk("ff_zero", 32'(bus.zero_q),   32'd1);
    chk("ff_pop",  32'(bus.popcnt_q), 32'd0);
    chk("ff_par",  32'(bus.parity_q), 32'd0);

    bus.a = 16'hAAAA;
    bus.b = 16'h5555;
    #1;
    chk("alt_comb", 32'(bus.out), 32'hFFFF);
    edge_wait();
    chk("alt_out_q", 32'(bus.out_q),    32'hFFFF);
    chk("alt_zero",  32'(bus.zero_q),   32'd0);
    chk("alt_pop",   32'(bus.popcnt_q), 32'd16);
    chk("alt_par",   32'(bus.parity_q), 32'd0);

    bus.a = 16'h0001;
    bus.b = 16'h0000;
    edge_wait();
    chk("one_out_q", 32'(bus.out_q), 32'h0001);
    bus.out_ready = 1'b0;
    bus.a         = 16'h1234;
    #1;
    chk("hold_ready0", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      chk("hold_ready", 32'(bus.in_ready),  32'd0);
      chk("hold_out_q", 32'(bus.out_q),     32'h0001);
      chk("hold_pop",   32'(bus.popcnt_q),  32'd1);
      chk("hold_par",   32'(bus.parity_q),  32'd1);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("rel_ready", 32'(bus.in_ready), 32'd1);
    edge_wait();
    chk("rel_out_q", 32'(bus.out_q),    32'h1234);
    chk("rel_pop",   32'(bus.popcnt_q), 32'd5);
    chk("rel_par",   32'(bus.parity_q), 32'd1);

    for (int i = 0; i < 4; i++) begin
      bus.a = sa[i];
      bus.b = sb[i];
      edge_wait();
      chk("str_out_q", 32'(bus.out_q),     32'(sx[i]));
      chk("str_pop",   32'(bus.popcnt_q),  32'(sp[i]));
      chk("str_zero",  32'(bus.zero_q),    32'(sx[i] == 16'h0000));
      chk("str_valid", 32'(bus.out_valid), 32'd1);
    end

    bus.in_valid = 1'b0;
    bus.a        = 16'h00FF;
    bus.b        = 16'h0F00;
    edge_wait();
    chk("idle_drain", 32'(bus.out_valid), 32'd0);
    chk("idle_hold",  32'(bus.out_q),     32'h0FF0);

    bus.in_valid = 1'b1;
    edge_wait();
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out_q", 32'(bus.out_q),     32'd0);
    chk("arst_zero",  32'(bus.zero_q),    32'd0);
    chk("arst_par",   32'(bus.parity_q),  32'd0);
    chk("arst_pop",   32'(bus.popcnt_q),  32'd0);
    chk("arst_ready", 32'(bus.in_ready),  32'd1);
    bus.a = 16'h1234;
    bus.b = 16'h00FF;
    #1;
    chk("arst_comb", 32'(bus.out), 32'h12CB);
    edge_wait();
    chk("arst_stay", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
